// File: rtl/conv_pe_sched.sv
// rtl/conv_pe_sched.sv - per-pixel, per-channel pass sequencer for one 5x5 conv PE
// Optional perf counters are enabled by defining CONV_PE_SCHED_PERF_EN.
module conv_pe_sched #(
  parameter int CH_W    = 5,
  parameter int PIX_W   = 12,
  parameter int SUM_LAT = 3,
  parameter int PE_LAT  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [PIX_W-1:0] cfg_num_pix,
  input  logic             cfg_relu,
  input  logic             cfg_quan,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [PIX_W-1:0] rd_pix,
  output logic [CH_W-1:0]  rd_ch,
  output logic             pe_valid_in,
  output logic [31:0]      pe_psum,
  output logic             pe_relu_en,
  output logic             pe_quan_en,
  input  logic             pe_valid_out,
  input  logic [7:0]       pe_out,
  input  logic [31:0]      pe_sum_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [31:0]      res_sum,
`ifdef CONV_PE_SCHED_PERF_EN
  output logic [31:0]      perf_busy_cyc,
  output logic [31:0]      perf_stall_cyc,
  output logic             perf_err,
`endif
  output logic [PIX_W-1:0] res_pix
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_SUM,
    S_WAIT_OUT,
    S_OUTPUT
  } state_t;

  localparam int CNT_W = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
  localparam logic [CNT_W-1:0] SUM_LAST = CNT_W'(SUM_LAT - 1);

  // WAIT_OUT relies on the final valid_out arriving after the sum was captured.
  if (SUM_LAT < 1 || PE_LAT <= SUM_LAT) begin : g_lat_check
    $error("conv_pe_sched: need 1 <= SUM_LAT < PE_LAT");
  end

  state_t           state_q;
  logic [CH_W-1:0]  ch_q;
  logic [CH_W-1:0]  last_ch_q;
  logic [CH_W-1:0]  rd_ch_q;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] last_pix_q;
  logic [PIX_W-1:0] rd_pix_q;
  logic [PIX_W-1:0] res_pix_q;
  logic [31:0]      acc_q;
  logic [31:0]      pe_psum_q;
  logic [31:0]      res_sum_q;
  logic [7:0]       res_data_q;
  logic [CNT_W-1:0] sum_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_en_q;
  logic             pe_valid_in_q;
  logic             relu_q;
  logic             quan_q;
  logic             res_valid_q;

  logic [CH_W-1:0]  ch_d;
  logic [PIX_W-1:0] pix_d;
  logic             ch_last;
  logic             pix_last;

  assign ch_d     = ch_q + 1'b1;
  assign pix_d    = pix_q + 1'b1;
  assign ch_last  = (ch_q == last_ch_q);
  assign pix_last = (pix_q == last_pix_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      last_ch_q     <= '0;
      rd_ch_q       <= '0;
      pix_q         <= '0;
      last_pix_q    <= '0;
      rd_pix_q      <= '0;
      res_pix_q     <= '0;
      acc_q         <= '0;
      pe_psum_q     <= '0;
      res_sum_q     <= '0;
      res_data_q    <= '0;
      sum_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      pe_valid_in_q <= 1'b0;
      relu_q        <= 1'b0;
      quan_q        <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      pe_valid_in_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        res_valid_q <= 1'b0;
        relu_q      <= 1'b0;
        quan_q      <= 1'b0;
        pe_psum_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              pix_q      <= '0;
              ch_q       <= '0;
              acc_q      <= '0;
              pe_psum_q  <= '0;
              last_ch_q  <= (cfg_num_ch == '0) ? '0 : cfg_num_ch - 1'b1;
              last_pix_q <= cfg_num_pix - 1'b1;
              if (cfg_num_pix == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q  <= S_FETCH;
                busy_q   <= 1'b1;
                relu_q   <= cfg_relu;
                quan_q   <= cfg_quan;
                rd_en_q  <= 1'b1;
                rd_pix_q <= '0;
                rd_ch_q  <= '0;
              end
            end
          end
          S_FETCH: begin
            state_q       <= S_ISSUE;
            pe_valid_in_q <= 1'b1;
            pe_psum_q     <= acc_q;
          end
          S_ISSUE: begin
            state_q   <= S_WAIT_SUM;
            sum_cnt_q <= '0;
          end
          S_WAIT_SUM: begin
            if (sum_cnt_q == SUM_LAST) begin
              acc_q <= pe_sum_out;
              if (ch_last) begin
                state_q <= S_WAIT_OUT;
              end else begin
                state_q  <= S_FETCH;
                ch_q     <= ch_d;
                rd_en_q  <= 1'b1;
                rd_pix_q <= pix_q;
                rd_ch_q  <= ch_d;
              end
            end else begin
              sum_cnt_q <= sum_cnt_q + 1'b1;
            end
          end
          S_WAIT_OUT: begin
            // Earlier channels' valid_out pulses land before this state is entered.
            if (pe_valid_out) begin
              res_data_q  <= pe_out;
              res_sum_q   <= acc_q;
              res_pix_q   <= pix_q;
              res_valid_q <= 1'b1;
              state_q     <= S_OUTPUT;
            end
          end
          S_OUTPUT: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              if (pix_last) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                relu_q  <= 1'b0;
                quan_q  <= 1'b0;
              end else begin
                state_q  <= S_FETCH;
                pix_q    <= pix_d;
                ch_q     <= '0;
                acc_q    <= '0;
                rd_en_q  <= 1'b1;
                rd_pix_q <= pix_d;
                rd_ch_q  <= '0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_pix      = rd_pix_q;
  assign rd_ch       = rd_ch_q;
  assign pe_valid_in = pe_valid_in_q;
  assign pe_psum     = pe_psum_q;
  assign pe_relu_en  = relu_q;
  assign pe_quan_en  = quan_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_sum     = res_sum_q;
  assign res_pix     = res_pix_q;

`ifdef CONV_PE_SCHED_PERF_EN
  logic        start_acc;
  logic [2:0]  outst_q;
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        perf_err_q;

  assign start_acc = (state_q == S_IDLE) && start && !abort;

  // Outstanding count survives start so stragglers from an aborted job are still tracked.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outst_q      <= '0;
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_err_q   <= 1'b0;
    end else begin
      case ({pe_valid_in_q, pe_valid_out})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   if (outst_q != '0) outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
      if (start_acc) begin
        perf_busy_q  <= '0;
        perf_stall_q <= '0;
        perf_err_q   <= 1'b0;
      end else begin
        if (busy_q) perf_busy_q <= perf_busy_q + 32'd1;
        if (state_q == S_OUTPUT && !res_ready) perf_stall_q <= perf_stall_q + 32'd1;
        if (pe_valid_out && outst_q == '0) perf_err_q <= 1'b1;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
  assign perf_err       = perf_err_q;
`endif

endmodule

// File: tb/tb_conv_pe_sched.sv
// tb/tb_conv_pe_sched.sv - directed and randomized bench for conv_pe_sched with a behavioural PE
module tb_conv_pe_sched;
  localparam int SUM_LAT = 3;
  localparam int PE_LAT  = 5;

  logic        clk, reset_n, start, abort;
  logic [4:0]  cfg_num_ch;
  logic [11:0] cfg_num_pix;
  logic        cfg_relu, cfg_quan;
  logic        busy, done, rd_en;
  logic [11:0] rd_pix;
  logic [4:0]  rd_ch;
  logic        pe_valid_in;
  logic [31:0] pe_psum;
  logic        pe_relu_en, pe_quan_en;
  logic        pe_valid_out;
  logic [7:0]  pe_out;
  logic [31:0] pe_sum_out;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic [31:0] res_sum;
  logic [11:0] res_pix;
`ifdef CONV_PE_SCHED_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
  logic        perf_err;
`endif

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct { int cyc; int pix; int ch; } rd_ev_t;
  typedef struct { int cyc; logic [31:0] psum; logic relu; logic quan; } iss_ev_t;
  rd_ev_t      rd_log[$];
  iss_ev_t     iss_log[$];
  logic [31:0] dot_tab [0:7][0:31];

  conv_pe_sched dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
    .cfg_relu(cfg_relu), .cfg_quan(cfg_quan),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_pix(rd_pix), .rd_ch(rd_ch),
    .pe_valid_in(pe_valid_in), .pe_psum(pe_psum),
    .pe_relu_en(pe_relu_en), .pe_quan_en(pe_quan_en),
    .pe_valid_out(pe_valid_out), .pe_out(pe_out), .pe_sum_out(pe_sum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sum(res_sum),
`ifdef CONV_PE_SCHED_PERF_EN
    .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc), .perf_err(perf_err),
`endif
    .res_pix(res_pix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // PE output stage: relu clamp, then >>>7 with signed 8-bit saturation when quantizing.
  function automatic logic [7:0] pe_f(input logic [31:0] s, input logic relu, input logic quan);
    logic signed [31:0] v;
    v = s;
    if (relu && v < 0) v = 0;
    if (!quan) return v[7:0];
    v = v >>> 7;
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // Behavioural PE: window.weight dot comes from dot_tab[pix][ch] of the last fetch.
  initial begin : pe_model
    bit          vin_h [0:PE_LAT];
    logic [31:0] sum_h [0:PE_LAT];
    logic [1:0]  cfg_h [0:PE_LAT];
    int          op_pix, op_ch;
    rd_ev_t      re;
    iss_ev_t     ie;
    pe_valid_out = 1'b0;
    pe_out = 8'h00;
    pe_sum_out = 32'h0;
    op_pix = 0;
    op_ch = 0;
    for (int k = 0; k <= PE_LAT; k++) begin
      vin_h[k] = 1'b0; sum_h[k] = '0; cfg_h[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = PE_LAT; k > 0; k--) begin
        vin_h[k] = vin_h[k-1]; sum_h[k] = sum_h[k-1]; cfg_h[k] = cfg_h[k-1];
      end
      vin_h[0] = 1'b0;
      sum_h[0] = '0;
      cfg_h[0] = '0;
      if (!reset_n) begin
        for (int k = 0; k <= PE_LAT; k++) vin_h[k] = 1'b0;
      end else begin
        if (pe_valid_in === 1'b1) begin
          vin_h[0] = 1'b1;
          sum_h[0] = pe_psum + dot_tab[op_pix][op_ch];
          cfg_h[0] = {pe_relu_en, pe_quan_en};
          ie.cyc = cyc; ie.psum = pe_psum; ie.relu = pe_relu_en; ie.quan = pe_quan_en;
          iss_log.push_back(ie);
        end
        if (rd_en === 1'b1) begin
          op_pix = int'(rd_pix) % 8;
          op_ch = int'(rd_ch);
          re.cyc = cyc; re.pix = int'(rd_pix); re.ch = int'(rd_ch);
          rd_log.push_back(re);
        end
      end
      if (vin_h[SUM_LAT]) pe_sum_out = sum_h[SUM_LAT];
      pe_valid_out = vin_h[PE_LAT];
      pe_out = vin_h[PE_LAT] ? pe_f(sum_h[PE_LAT], cfg_h[PE_LAT][1], cfg_h[PE_LAT][0]) : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_job(input int nch, input int npix, input bit relu, input bit quan,
                         input int stall, output int t_start, output int t_res0,
                         output logic [7:0] last_data, output logic [31:0] last_sum);
    int          eff, rd0, is0, w, idx;
    logic [31:0] acc;
    logic [7:0]  exp_d;
    eff = (nch == 0) ? 1 : nch;
    rd0 = rd_log.size();
    is0 = iss_log.size();
    t_res0 = -1;
    last_data = '0;
    last_sum = '0;
    tick();
    cfg_num_ch = 5'(nch); cfg_num_pix = 12'(npix); cfg_relu = relu; cfg_quan = quan;
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
    for (int p = 0; p < npix; p++) begin
      acc = '0;
      for (int c = 0; c < eff; c++) acc = acc + dot_tab[p][c];
      exp_d = pe_f(acc, relu, quan);
      w = 0;
      while (res_valid !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      check("res_timeout", res_valid, 1'b1);
      if (p == 0) t_res0 = cyc;
      check("res_sum", res_sum, acc);
      check("res_data", res_data, exp_d);
      check("res_pix", res_pix, p);
      last_data = res_data;
      last_sum = res_sum;
      for (int k = 0; k < stall; k++) begin
        tick();
        check("stall_hold", {res_valid, res_data, res_sum, res_pix}, {1'b1, exp_d, acc, 12'(p)});
        check("stall_no_rd", rd_en, 1'b0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("res_clear", res_valid, 1'b0);
      if (p == npix - 1) begin
        check("done_pulse", {done, busy}, 2'b10);
        tick();
        check("done_low", done, 1'b0);
      end else begin
        check("next_fetch", {rd_en, rd_pix}, {1'b1, 12'(p + 1)});
      end
    end
    check("rd_count", rd_log.size() - rd0, eff * npix);
    check("iss_count", iss_log.size() - is0, eff * npix);
    if (rd_log.size() - rd0 == eff * npix && iss_log.size() - is0 == eff * npix) begin
      for (int p = 0; p < npix; p++) begin
        acc = '0;
        for (int c = 0; c < eff; c++) begin
          idx = p * eff + c;
          check("rd_pix_ch", {rd_log[rd0 + idx].pix, rd_log[rd0 + idx].ch}, {p, c});
          check("iss_psum", iss_log[is0 + idx].psum, acc);
          check("iss_cfg", {iss_log[is0 + idx].relu, iss_log[is0 + idx].quan}, {relu, quan});
          acc = acc + dot_tab[p][c];
        end
      end
    end
  endtask

  initial begin
    int          ts, tr, b, w, nch, npix, stall;
    bit          relu, quan, seen_done, seen_rv, seen_rd;
    logic [7:0]  d;
    logic [31:0] s;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cfg_num_ch = '0; cfg_num_pix = '0; cfg_relu = 1'b0; cfg_quan = 1'b0;
    for (int p = 0; p < 8; p++) for (int c = 0; c < 32; c++) dot_tab[p][c] = '0;
    repeat (3) tick();
    check("rst_ctl", {busy, done, rd_en, pe_valid_in, pe_relu_en, pe_quan_en, res_valid}, 7'b0);
    check("rst_psum", pe_psum, 32'h0);
    check("rst_res", {res_data, res_sum, res_pix}, 52'h0);
    check("rst_rd", {rd_pix, rd_ch}, 17'h0);
    reset_n = 1'b1;
    tick();

    // 1 ch, 1 pix, IF=128 W=1: dot = 25*128
    dot_tab[0][0] = 32'd3200;
    b = iss_log.size();
    w = rd_log.size();
    run_job(1, 1, 1'b1, 1'b1, 2, ts, tr, d, s);
    check("t1_rd_cycle", rd_log[w].cyc - ts, 1);
    check("t1_issue_cycle", iss_log[b].cyc - ts, 2);
    check("t1_res_cycle", tr - ts, 8);
    check("t1_data", d, 8'd25);
    check("t1_sum", s, 32'd3200);

    // 3 ch chaining
    for (int c = 0; c < 3; c++) dot_tab[0][c] = 32'd3200;
    b = iss_log.size();
    run_job(3, 1, 1'b1, 1'b1, 0, ts, tr, d, s);
    check("t2_psum", {iss_log[b].psum, iss_log[b+1].psum, iss_log[b+2].psum}, {32'd0, 32'd3200, 32'd6400});
    check("t2_gap", {iss_log[b+1].cyc - iss_log[b].cyc, iss_log[b+2].cyc - iss_log[b+1].cyc}, {32'd5, 32'd5});
    check("t2_sum", s, 32'd9600);
    check("t2_data", d, 8'd75);

    // negative weight with relu
    dot_tab[0][0] = -32'sd3200;
    run_job(1, 1, 1'b1, 1'b1, 0, ts, tr, d, s);
    check("t3_sum", s, 32'hFFFFF380);
    check("t3_data", d, 8'd0);

    // 2 pix, 2 ch, backpressure on pix 0
    for (int p = 0; p < 2; p++) for (int c = 0; c < 2; c++) dot_tab[p][c] = $urandom_range(0, 100000);
    run_job(2, 2, 1'b0, 1'b1, 10, ts, tr, d, s);

    // abort during WAIT_SUM of channel 1
    for (int c = 0; c < 3; c++) dot_tab[0][c] = 32'd3200;
    b = iss_log.size();
    tick();
    cfg_num_ch = 5'd3; cfg_num_pix = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (iss_log.size() < b + 2 && w < 100) begin
      tick();
      w++;
    end
    check("abort_reach", iss_log.size() >= b + 2, 1'b1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, res_valid, done}, 3'b000);
    seen_done = 0; seen_rv = 0; seen_rd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen_done |= done; seen_rv |= res_valid; seen_rd |= rd_en;
    end
    check("abort_quiet", {seen_done, seen_rv, seen_rd, busy}, 4'b0000);

    // start while busy is ignored
    dot_tab[0][0] = $urandom;
    fork
      begin
        repeat (5) tick();
        cfg_num_ch = 5'd9; cfg_num_pix = 12'd7; cfg_relu = 1'b1; cfg_quan = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join_none
    run_job(1, 1, 1'b0, 1'b0, 1, ts, tr, d, s);
    repeat (3) tick();
    check("busy_start_idle", {busy, rd_en}, 2'b00);

    // zero-pixel job
    w = rd_log.size();
    cfg_num_pix = '0; cfg_num_ch = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_pix_done", {done, busy}, 2'b10);
    tick();
    check("zero_pix_done_low", done, 1'b0);
    repeat (5) tick();
    check("zero_pix_no_rd", rd_log.size() - w, 0);

    // reset mid-job
    dot_tab[0][0] = 32'd1; dot_tab[0][1] = 32'd2;
    cfg_num_ch = 5'd2; cfg_num_pix = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    check("midrst_ctl", {busy, done, rd_en, pe_valid_in, pe_relu_en, pe_quan_en, res_valid}, 7'b0);
    check("midrst_psum", pe_psum, 32'h0);
    reset_n = 1'b1;
    repeat (8) tick();
    check("midrst_quiet", {busy, res_valid}, 2'b00);

    // randomized jobs, including num_ch=0 and wrapping sums
    for (int j = 0; j < 8; j++) begin
      nch = $urandom_range(0, 4);
      npix = $urandom_range(1, 3);
      relu = 1'($urandom_range(0, 1));
      quan = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      for (int p = 0; p < npix; p++) for (int c = 0; c < 5; c++) dot_tab[p][c] = $urandom;
      run_job(nch, npix, relu, quan, stall, ts, tr, d, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_pe_sched.md
Name: conv_pe_sched

Overview:
- Sequencer for one 5x5 convolution PE (5-cycle valid pipeline, psum input, sum_out tap).
- For each output pixel, iterates over input channels: requests window and weights from the feature/weight buffer, issues one PE pass per channel, and feeds sum_out back as psum.
- Returns the final quantized pixel with a valid/ready handshake.
- Sits between the layer-level control (start/config) and the PE plus its operand buffers.

Parameters:
- CH_W, 5: width of the channel count and index.
- PIX_W, 12: width of the pixel count and index.
- SUM_LAT, 3: cycles from PE valid_in to stable sum_out.
- PE_LAT, 5: cycles from PE valid_in to PE valid_out.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- abort  in  1  soft abort; returns to IDLE next cycle
- cfg_num_ch  in  CH_W  input channels per pixel; 0 is treated as 1
- cfg_num_pix  in  PIX_W  output pixels in the job
- cfg_relu  in  1  ReLU enable, latched at start
- cfg_quan  in  1  quantization enable, latched at start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at job end
- rd_en  out  1  operand fetch strobe; buffer data is valid on the following cycle
- rd_pix  out  PIX_W  pixel index of the fetch
- rd_ch  out  CH_W  channel index of the fetch
- pe_valid_in  out  1  PE valid_in
- pe_psum  out  32  PE psum
- pe_relu_en  out  1  PE relu_en
- pe_quan_en  out  1  PE quan_en
- pe_valid_out  in  1  PE valid_out
- pe_out  in  8  PE pe_out
- pe_sum_out  in  32  PE sum_out
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_data  out  8  quantized pixel
- res_sum  out  32  full-precision accumulated sum (pre-ReLU)
- res_pix  out  PIX_W  pixel index of the result

Behaviour:
- Reset (synchronous, reset_n=0): state IDLE. All outputs 0, including busy, done, rd_en, pe_valid_in, pe_psum, pe_relu_en, pe_quan_en, res_valid, res_data, res_sum, res_pix, rd_pix and rd_ch. Internal acc, ch and pix counters are 0. Reset mid-job drops the job; PE results still in flight are ignored.
- States: IDLE, FETCH, ISSUE, WAIT_SUM, WAIT_OUT, OUTPUT.
- IDLE:
  - start=1 latches the config, sets pix=0, ch=0, acc=0.
  - If cfg_num_pix=0: pulse done the next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH (1 cycle): rd_en=1, rd_pix=pix, rd_ch=ch. Next state is ISSUE.
- ISSUE (1 cycle): pe_valid_in=1. pe_psum is a register equal to acc (0 on channel 0) and is held stable throughout the pass.
- WAIT_SUM (SUM_LAT cycles, counted from the cycle after ISSUE): on the last cycle, acc <= pe_sum_out.
  - If ch is not the last channel: ch++ and go to FETCH. One channel takes 5 cycles.
  - If ch is the last channel: go to WAIT_OUT.
- WAIT_OUT: wait until pe_valid_out=1, which is PE_LAT cycles after ISSUE.
  - Latch res_data=pe_out, res_sum=acc, res_pix=pix.
  - Set res_valid=1 and go to OUTPUT.
- OUTPUT: hold res_valid and res_* until res_ready=1. On acceptance, clear res_valid.
  - If pix is the last pixel: pulse done and go to IDLE.
  - Otherwise pix++, ch=0, acc=0, and go to FETCH.
- pe_relu_en and pe_quan_en are driven from the latched config for the whole job. Intermediate-channel pe_out values are ignored, and sum_out is pre-ReLU, so psum chaining is unaffected.
- acc is 32-bit two's complement and wraps on overflow with no saturation; saturation is the PE's job.
- start while busy is ignored; config is not re-latched.
- abort has priority over every state transition. Next cycle: IDLE, res_valid=0, no done pulse.
- Simultaneous res_ready and abort: abort wins and the result is dropped.
- Only one PE pass is in flight at a time, so no pipeline overlap is needed.

Optional Feature:
- Macro: CONV_PE_SCHED_PERF_EN.
- When defined, adds:
  - outputs perf_busy_cyc[31:0], counting cycles with busy=1;
  - perf_stall_cyc[31:0], counting cycles in OUTPUT with res_ready=0;
  - perf_err, a sticky flag set when pe_valid_out=1 while the number of outstanding issues is 0.
- All three are cleared by reset and by start acceptance.
- When undefined: no such ports and no counter logic.

Test Plan:
- 1 ch, 1 pix, all IF=128, W=1, quan=1, relu=1; start at cycle 0:
  - rd_en high in cycle 1 and pe_valid_in high in cycle 2;
  - res_valid rises in cycle 8 with res_data=25 and res_sum=3200;
  - done pulses 1 cycle after res_ready.
- 3 ch, IF=128, W=1:
  - pe_psum takes 0, then 3200, then 6400 on successive ISSUEs, 5 cycles apart;
  - res_sum=9600, res_data=75.
- 1 ch, IF=128, W=-1, relu=1, quan=1: res_sum=-3200 (0xFFFFF380), res_data=0.
- 2 pix, 2 ch, res_ready held low 10 cycles on pix 0:
  - res_valid and res_* stay stable throughout;
  - no rd_en until accept;
  - pix 1 is then processed with acc restarted at 0.
- Abort issued during WAIT_SUM of channel 1: IDLE next cycle, busy=0, no done, no res_valid.
- start while busy ignored; cfg_num_pix=0: done pulses in cycle 1, rd_en never asserted.
